pcie_dllp_rx_decoder: RTL and testbench

//  Receive-side DLLP parser for the PCIe data link layer. Takes byte-serial DLLPs (6 B, after framing strip)
//  on AXI-Stream and checks CRC-16. Decodes the type byte and extracts the Ack/Nak sequence number or
//  FC credits. Tracks InitFC1/InitFC2 reception for one VC and feeds the DL FC-init FSM and replay logic.

---
 rtl/pcie_dllp_rx_decoder_if.sv | 16 +
 rtl/pcie_dllp_rx_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_pcie_dllp_rx_decoder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_dllp_rx_decoder_if.sv
// Byte-serial AXI-Stream link carrying framed-stripped DLLPs.
//   tdata  : DLLP byte (byte0 = type, byte4/5 = CRC)
//   tvalid : byte valid
//   tready : sink can take a byte
//   tlast  : last byte of the DLLP
// Handshake: a byte moves on a rising clk edge where tvalid && tready are both 1;
// the source holds tdata/tlast stable while tvalid is high and tready is low.
interface pcie_dllp_rx_decoder_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pcie_dllp_rx_decoder.sv
// Receive-side DLLP parser. Collects 6-byte DLLPs, checks the CRC-16, decodes
// Ack/Nak/PM/Vendor/FC types, and tracks InitFC1/InitFC2 progress for one VC.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_axis          byte stream in (slave modport)
//   dl_down         level, clears init flags
//   ack/nak_valid   1-cycle pulses, acknak_seq held 12-bit sequence number
//   fc_*            FC DLLP pulse and fields (held between pulses)
//   pm_valid/pm_type, vendor_valid
//   crc_err/len_err/unk_err  1-cycle error pulses
//   fi1_seen/fi1_done/fi2_done  sticky init-tracking flags for VC_ID
//   good_cnt/bad_cnt  saturating DLLP counters
//   dbg_state       current FSM state (0 idle, 1 collect, 2 drop)
module pcie_dllp_rx_decoder #(
  parameter int VC_ID     = 0,
  parameter int CNT_WIDTH = 16,
  parameter bit CRC_CHECK = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  pcie_dllp_rx_decoder_if.slave     s_axis,
  input  logic                      dl_down,
  output logic                      ack_valid,
  output logic                      nak_valid,
  output logic [11:0]               acknak_seq,
  output logic                      fc_valid,
  output logic [1:0]                fc_kind,
  output logic [1:0]                fc_class,
  output logic [2:0]                fc_vc,
  output logic [7:0]                fc_hdr,
  output logic [11:0]               fc_data,
  output logic                      pm_valid,
  output logic [7:0]                pm_type,
  output logic                      vendor_valid,
  output logic                      crc_err,
  output logic                      len_err,
  output logic                      unk_err,
  output logic [2:0]                fi1_seen,
  output logic                      fi1_done,
  output logic                      fi2_done,
  output logic [CNT_WIDTH-1:0]      good_cnt,
  output logic [CNT_WIDTH-1:0]      bad_cnt,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DROP = 2'd2} state_t;

  state_t      state, state_next;
  logic [2:0]  idx, idx_next;
  logic        accept, complete, len_bad;

  // Only the header/data bits that feed outputs are kept for bytes 1 and 2.
  logic [7:0]  b0_q, b3_q, b4_q;
  logic [5:0]  b1_q;
  logic [1:0]  b2_hi_q;
  logic [3:0]  b2_lo_q;
  logic [15:0] crc_q, crc_in, crc_upd, crc_c;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h100B;
    end
    return r;
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  assign s_axis.tready = (state != S_IDLE);
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign dbg_state     = state;
  assign fi1_done      = &fi1_seen;

  // FSM: next state, byte index, and frame-level events
  always_comb begin
    state_next = state;
    idx_next   = idx;
    complete   = 1'b0;
    len_bad    = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_COLLECT;
        idx_next   = 3'd0;
      end
      S_COLLECT: begin
        if (accept) begin
          if (s_axis.tlast) begin
            if (idx == 3'd5) complete = 1'b1;
            else             len_bad  = 1'b1;
            idx_next = 3'd0;
          end else if (idx == 3'd5) begin
            len_bad    = 1'b1;
            state_next = S_DROP;
            idx_next   = 3'd0;
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
      S_DROP: begin
        if (accept && s_axis.tlast) begin
          state_next = S_COLLECT;
          idx_next   = 3'd0;
        end
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // CRC restarts from the seed on byte 0 so no separate clear is needed.
  assign crc_in  = (idx == 3'd0) ? 16'hFFFF : crc_q;
  assign crc_upd = crc_byte(crc_in, s_axis.tdata);
  assign crc_c   = ~crc_q;

  // Decode of the completed DLLP (byte 5 is the live input byte)
  logic       crc_bad, is_ack, is_nak, is_pm, is_vendor, is_fc, unk, good;
  logic [1:0] kind;

  always_comb begin
    crc_bad   = (b4_q != bitrev8(crc_c[15:8])) || (s_axis.tdata != bitrev8(crc_c[7:0]));
    is_ack    = (b0_q == 8'h00);
    is_nak    = (b0_q == 8'h10);
    is_pm     = (b0_q == 8'h20) || (b0_q == 8'h21) || (b0_q == 8'h23) || (b0_q == 8'h24);
    is_vendor = (b0_q == 8'h30);
    // High nibble 4-6 / C-E / 8-A; class is bits [5:4] in all three groups
    is_fc     = (b0_q[7:6] != 2'b00) && (b0_q[5:4] != 2'b11);
    kind      = 2'd0;
    case (b0_q[7:6])
      2'b01:   kind = 2'd0;
      2'b11:   kind = 2'd1;
      2'b10:   kind = 2'd2;
      default: kind = 2'd0;
    endcase
    unk  = !(is_ack || is_nak || is_pm || is_vendor || is_fc);
    good = !((crc_bad && CRC_CHECK) || unk);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 16'hFFFF;
      b0_q <= '0; b1_q <= '0; b2_hi_q <= '0; b2_lo_q <= '0; b3_q <= '0; b4_q <= '0;
      ack_valid <= 1'b0; nak_valid <= 1'b0; acknak_seq <= '0;
      fc_valid <= 1'b0; fc_kind <= '0; fc_class <= '0; fc_vc <= '0; fc_hdr <= '0; fc_data <= '0;
      pm_valid <= 1'b0; pm_type <= '0; vendor_valid <= 1'b0;
      crc_err <= 1'b0; len_err <= 1'b0; unk_err <= 1'b0;
      fi1_seen <= '0; fi2_done <= 1'b0;
      good_cnt <= '0; bad_cnt <= '0;
    end else begin
      ack_valid <= 1'b0; nak_valid <= 1'b0; fc_valid <= 1'b0;
      pm_valid <= 1'b0; vendor_valid <= 1'b0;
      crc_err <= 1'b0; unk_err <= 1'b0;
      len_err <= len_bad;

      if (accept && state == S_COLLECT && idx < 3'd4) crc_q <= crc_upd;
      if (accept && state == S_COLLECT) begin
        case (idx)
          3'd0: b0_q <= s_axis.tdata;
          3'd1: b1_q <= s_axis.tdata[5:0];
          3'd2: begin b2_hi_q <= s_axis.tdata[7:6]; b2_lo_q <= s_axis.tdata[3:0]; end
          3'd3: b3_q <= s_axis.tdata;
          3'd4: b4_q <= s_axis.tdata;
          default: ;
        endcase
      end

      if (complete) begin
        crc_err <= crc_bad;
        unk_err <= !crc_bad && unk;
        if (good) begin
          if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
          if (is_ack || is_nak) begin
            ack_valid  <= is_ack;
            nak_valid  <= is_nak;
            acknak_seq <= {b2_lo_q, b3_q};
          end
          if (is_pm) begin
            pm_valid <= 1'b1;
            pm_type  <= b0_q;
          end
          if (is_vendor) vendor_valid <= 1'b1;
          if (is_fc) begin
            fc_valid <= 1'b1;
            fc_kind  <= kind;
            fc_class <= b0_q[5:4];
            fc_vc    <= b0_q[2:0];
            fc_hdr   <= {b1_q, b2_hi_q};
            fc_data  <= {b2_lo_q, b3_q};
          end
        end else begin
          if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
        end
      end else if (len_bad) begin
        if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
      end

      // dl_down has priority over any same-cycle set
      if (dl_down) begin
        fi1_seen <= '0;
        fi2_done <= 1'b0;
      end else if (complete && good && is_fc && (b0_q[2:0] == 3'(VC_ID))) begin
        if (kind == 2'd0) fi1_seen[b0_q[5:4]] <= 1'b1;
        else              fi2_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_dllp_rx_decoder.sv
module tb_pcie_dllp_rx_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dl_down = 1'b0;
  always #5 clk = ~clk;

  pcie_dllp_rx_decoder_if axis_a ();
  pcie_dllp_rx_decoder_if axis_b ();

  logic        ack_valid, nak_valid, fc_valid, pm_valid, vendor_valid;
  logic        crc_err, len_err, unk_err, fi1_done, fi2_done;
  logic [11:0] acknak_seq, fc_data;
  logic [1:0]  fc_kind, fc_class, dbg_state;
  logic [2:0]  fc_vc, fi1_seen;
  logic [7:0]  fc_hdr, pm_type;
  logic [15:0] good_cnt, bad_cnt;

  logic        nc_ack_valid, nc_nak_valid, nc_fc_valid, nc_pm_valid, nc_vendor_valid;
  logic        nc_crc_err, nc_len_err, nc_unk_err, nc_fi1_done, nc_fi2_done;
  logic [11:0] nc_acknak_seq, nc_fc_data;
  logic [1:0]  nc_fc_kind, nc_fc_class, nc_dbg_state;
  logic [2:0]  nc_fc_vc, nc_fi1_seen;
  logic [7:0]  nc_fc_hdr, nc_pm_type;
  logic [15:0] nc_good_cnt, nc_bad_cnt;

  pcie_dllp_rx_decoder dut (
    .clk(clk), .rst(rst), .s_axis(axis_a), .dl_down(dl_down),
    .ack_valid(ack_valid), .nak_valid(nak_valid), .acknak_seq(acknak_seq),
    .fc_valid(fc_valid), .fc_kind(fc_kind), .fc_class(fc_class), .fc_vc(fc_vc),
    .fc_hdr(fc_hdr), .fc_data(fc_data), .pm_valid(pm_valid), .pm_type(pm_type),
    .vendor_valid(vendor_valid), .crc_err(crc_err), .len_err(len_err), .unk_err(unk_err),
    .fi1_seen(fi1_seen), .fi1_done(fi1_done), .fi2_done(fi2_done),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt), .dbg_state(dbg_state)
  );

  pcie_dllp_rx_decoder #(.CRC_CHECK(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .s_axis(axis_b), .dl_down(dl_down),
    .ack_valid(nc_ack_valid), .nak_valid(nc_nak_valid), .acknak_seq(nc_acknak_seq),
    .fc_valid(nc_fc_valid), .fc_kind(nc_fc_kind), .fc_class(nc_fc_class), .fc_vc(nc_fc_vc),
    .fc_hdr(nc_fc_hdr), .fc_data(nc_fc_data), .pm_valid(nc_pm_valid), .pm_type(nc_pm_type),
    .vendor_valid(nc_vendor_valid), .crc_err(nc_crc_err), .len_err(nc_len_err), .unk_err(nc_unk_err),
    .fi1_seen(nc_fi1_seen), .fi1_done(nc_fi1_done), .fi2_done(nc_fi2_done),
    .good_cnt(nc_good_cnt), .bad_cnt(nc_bad_cnt), .dbg_state(nc_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Pulse counters, sampled on the falling edge
  int mon_ack = 0, mon_len = 0, mon_fc = 0, mon_unk = 0;
  always @(negedge clk) begin
    if (ack_valid) mon_ack++;
    if (len_err)   mon_len++;
    if (fc_valid)  mon_fc++;
    if (unk_err)   mon_unk++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reflected (shift-right) form of the CRC; returns {byte4, byte5}
  function automatic logic [15:0] dllp_crc(input logic [7:0] b0, b1, b2, b3);
    logic [15:0] r;
    logic [7:0]  d;
    logic        fb;
    r = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? b0 : (k == 1) ? b1 : (k == 2) ? b2 : b3;
      for (int i = 0; i < 8; i++) begin
        fb = r[0] ^ d[i];
        r  = r >> 1;
        if (fb) r = r ^ 16'hD008;
      end
    end
    return {~r[7:0], ~r[15:8]};
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last);
    int w;
    @(negedge clk);
    axis_a.tdata = d; axis_a.tvalid = 1'b1; axis_a.tlast = last;
    axis_b.tdata = d; axis_b.tvalid = 1'b1; axis_b.tlast = last;
    w = 0;
    while (!axis_a.tready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!axis_a.tready) begin
      checks++;
      errors++;
      $display("FAIL tready_timeout got 0 expected 1");
    end
    @(posedge clk);
  endtask

  task automatic send_dllp(input logic [7:0] t, b1, b2, b3, input logic flip4);
    logic [15:0] c;
    c = dllp_crc(t, b1, b2, b3);
    if (flip4) c[8] = ~c[8];
    send_byte(t, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    send_byte(b3, 1'b0);
    send_byte(c[15:8], 1'b0);
    send_byte(c[7:0], 1'b1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    axis_a.tvalid = 1'b0; axis_a.tlast = 1'b0;
    axis_b.tvalid = 1'b0; axis_b.tlast = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int snap_ack, snap_len, snap_fc, snap_unk;
  logic [15:0] crc_tmp;

  initial begin
    axis_a.tdata = 8'h00; axis_a.tvalid = 1'b0; axis_a.tlast = 1'b0;
    axis_b.tdata = 8'h00; axis_b.tvalid = 1'b0; axis_b.tlast = 1'b0;

    // Reset state
    #12;
    chk("rst_tready", axis_a.tready, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_ack_valid", ack_valid, 0);
    chk("rst_good_cnt", good_cnt, 0);
    chk("rst_bad_cnt", bad_cnt, 0);
    chk("rst_fi1_seen", fi1_seen, 0);
    @(negedge clk);
    rst = 1'b0;

    // Ack, seq 0x5A3
    send_dllp(8'h00, 8'h00, 8'h05, 8'hA3, 1'b0);
    #1;
    chk("ack_valid", ack_valid, 1);
    chk("ack_seq", acknak_seq, 12'h5A3);
    chk("ack_good_cnt", good_cnt, 1);
    idle(0);
    @(posedge clk); #1;
    chk("ack_pulse_width", ack_valid, 0);
    chk("ack_seq_held", acknak_seq, 12'h5A3);

    // InitFC1 P/NP/Cpl on VC0, hdr 0x01 data 0x040
    send_dllp(8'h40, 8'h00, 8'h40, 8'h40, 1'b0);
    #1;
    chk("fi1p_fc_valid", fc_valid, 1);
    chk("fi1p_kind", fc_kind, 0);
    chk("fi1p_class", fc_class, 0);
    send_dllp(8'h50, 8'h00, 8'h40, 8'h40, 1'b0);
    #1;
    chk("fi1np_class", fc_class, 1);
    send_dllp(8'h60, 8'h00, 8'h40, 8'h40, 1'b0);
    #1;
    chk("fi1cpl_class", fc_class, 2);
    chk("fi1_hdr", fc_hdr, 8'h01);
    chk("fi1_data", fc_data, 12'h040);
    chk("fi1_vc", fc_vc, 0);
    chk("fi1_seen_all", fi1_seen, 3'b111);
    chk("fi1_done", fi1_done, 1);
    chk("fi2_done_clear", fi2_done, 0);
    chk("fi1_good_cnt", good_cnt, 4);
    idle(0);
    dl_down = 1'b1;
    @(negedge clk);
    dl_down = 1'b0;
    chk("dl_down_fi1_seen", fi1_seen, 0);
    chk("dl_down_fi1_done", fi1_done, 0);

    // dl_down held through a good InitFC1: clear beats set
    dl_down = 1'b1;
    send_dllp(8'h40, 8'h00, 8'h40, 8'h40, 1'b0);
    #1;
    chk("dl_win_fc_valid", fc_valid, 1);
    chk("dl_win_fi1_seen", fi1_seen, 0);
    idle(0);
    dl_down = 1'b0;

    // Nak with corrupted CRC byte 4
    send_dllp(8'h10, 8'h00, 8'h01, 8'h23, 1'b1);
    #1;
    chk("nak_crc_err", crc_err, 1);
    chk("nak_suppressed", nak_valid, 0);
    chk("nak_unk_err", unk_err, 0);
    chk("nak_bad_cnt", bad_cnt, 1);
    chk("nc_nak_valid", nc_nak_valid, 1);
    chk("nc_crc_err", nc_crc_err, 1);
    chk("nc_nak_seq", nc_acknak_seq, 12'h123);
    idle(1);

    // Short frame: tlast on byte 3
    send_byte(8'h90, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h81, 1'b0);
    send_byte(8'h55, 1'b1);
    #1;
    chk("short_len_err", len_err, 1);
    chk("short_bad_cnt", bad_cnt, 2);
    idle(1);

    // UpdateFC NP VC0, hdr 0x22 data 0x155
    send_dllp(8'h90, 8'h08, 8'h81, 8'h55, 1'b0);
    #1;
    chk("upd_fc_valid", fc_valid, 1);
    chk("upd_kind", fc_kind, 2);
    chk("upd_class", fc_class, 1);
    chk("upd_hdr", fc_hdr, 8'h22);
    chk("upd_data", fc_data, 12'h155);
    chk("upd_fi2_done", fi2_done, 1);
    chk("upd_good_cnt", good_cnt, 6);
    idle(1);

    // 8-byte frame: one len_err, remainder dropped
    snap_ack = mon_ack; snap_len = mon_len;
    crc_tmp = dllp_crc(8'h00, 8'h00, 8'h00, 8'h11);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(crc_tmp[15:8], 1'b0);
    send_byte(crc_tmp[7:0], 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    idle(2);
    chk("long_len_pulses", mon_len - snap_len, 1);
    chk("long_no_ack", mon_ack - snap_ack, 0);
    chk("long_bad_cnt", bad_cnt, 3);

    // Unknown type 0x70 with valid CRC
    snap_unk = mon_unk; snap_fc = mon_fc;
    send_dllp(8'h70, 8'h00, 8'h00, 8'h00, 1'b0);
    #1;
    chk("unk_err", unk_err, 1);
    chk("unk_crc_err", crc_err, 0);
    idle(2);
    chk("unk_pulses", mon_unk - snap_unk, 1);
    chk("unk_no_fc", mon_fc - snap_fc, 0);
    chk("unk_bad_cnt", bad_cnt, 4);

    // PM and Vendor
    send_dllp(8'h20, 8'h00, 8'h00, 8'h00, 1'b0);
    #1;
    chk("pm_valid", pm_valid, 1);
    chk("pm_type", pm_type, 8'h20);
    idle(0);
    send_dllp(8'h30, 8'h12, 8'h34, 8'h56, 1'b0);
    #1;
    chk("vendor_valid", vendor_valid, 1);
    chk("vendor_good_cnt", good_cnt, 8);
    idle(1);

    // Ten back-to-back Acks, tvalid held high throughout
    snap_ack = mon_ack;
    for (int i = 0; i < 10; i++) send_dllp(8'h00, 8'h00, 8'h01, 8'(i), 1'b0);
    idle(2);
    chk("b2b_ack_pulses", mon_ack - snap_ack, 10);
    chk("b2b_last_seq", acknak_seq, 12'h109);
    chk("b2b_good_cnt", good_cnt, 18);
    chk("b2b_bad_cnt", bad_cnt, 4);

    // Reset in the middle of a DLLP, then a clean Ack
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    axis_a.tvalid = 1'b0; axis_b.tvalid = 1'b0;
    axis_a.tlast = 1'b0; axis_b.tlast = 1'b0;
    @(negedge clk);
    chk("midrst_tready", axis_a.tready, 0);
    chk("midrst_good_cnt", good_cnt, 0);
    rst = 1'b0;
    send_dllp(8'h00, 8'h00, 8'h05, 8'hA3, 1'b0);
    #1;
    chk("midrst_ack_valid", ack_valid, 1);
    chk("midrst_ack_seq", acknak_seq, 12'h5A3);
    chk("midrst_good_one", good_cnt, 1);
    chk("midrst_bad_zero", bad_cnt, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
